// File: rtl/rf_port_scheduler_if.sv
// Signal bundle between rf_port_scheduler, its writeback/issue clients and the banked register file.
// The scheduler uses the slave modport; the environment around it uses master.
`ifndef NUM_PR
`define NUM_PR 64
`endif

interface rf_port_scheduler_if #(
    parameter int NUM_BRAMS = 4,
    parameter int PR_W      = $clog2(`NUM_PR)
);
    localparam int NUM_RD = 2 * NUM_BRAMS;

    logic [1:0]                  wr_valid;
    logic [1:0][PR_W-1:0]        wr_addr;
    logic [1:0][31:0]            wr_data;
    logic                        wr_ready;
    logic                        rd_valid;
    logic [NUM_RD-1:0]           rd_mask;
    logic [NUM_RD-1:0][PR_W-1:0] rd_addr;
    logic                        rd_ready;
    logic                        rsp_valid;
    logic [NUM_RD-1:0]           rsp_mask;
    logic [NUM_RD-1:0][31:0]     rsp_data;
    logic [1:0]                  rf_mode;
    logic [1:0][PR_W-1:0]        rf_write_addr;
    logic [1:0][31:0]            rf_write_data;
    logic [NUM_RD-1:0][PR_W-1:0] rf_read_addr;
    logic [NUM_RD-1:0][31:0]     rf_read_data;

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_mask, rd_addr, rf_read_data,
        output wr_ready, rd_ready, rsp_valid, rsp_mask, rsp_data,
               rf_mode, rf_write_addr, rf_write_data, rf_read_addr
    );

    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_mask, rd_addr, rf_read_data,
        input  wr_ready, rd_ready, rsp_valid, rsp_mask, rsp_data,
               rf_mode, rf_write_addr, rf_write_data, rf_read_addr
    );
endinterface

// File: rtl/rf_port_scheduler.sv
// Per-cycle port scheduler for the banked multi-BRAM register file: write FIFO, read acceptance, mode pick.
// Optional feature macro RF_WBUF_BYPASS_EN: forward pending FIFO data to reads instead of stalling them.
`ifndef NUM_PR
`define NUM_PR 64
`endif

module rf_port_scheduler #(
    parameter int NUM_BRAMS  = 4,
    parameter int WBUF_DEPTH = 8,
    parameter int PR_W       = $clog2(`NUM_PR)
) (
    input logic                clk,
    input logic                reset,
    rf_port_scheduler_if.slave bus
);
    localparam int NUM_RD = 2 * NUM_BRAMS;
    localparam int PTR_W  = $clog2(WBUF_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [1:0] MODE_WR2   = 2'b00;
    localparam logic [1:0] MODE_WR1RD = 2'b01;
    localparam logic [1:0] MODE_RD2   = 2'b10;
    localparam logic [1:0] MODE_IDLE  = 2'b11;

    logic [PR_W-1:0]         fifo_addr_q [WBUF_DEPTH];
    logic [31:0]             fifo_data_q [WBUF_DEPTH];
    logic [PTR_W-1:0]        head_q, tail_q;
    logic [CNT_W-1:0]        count_q;
    logic                    rsp_valid_q;
    logic [NUM_RD-1:0]       rsp_mask_q;

    logic [WBUF_DEPTH-1:0]   ent_valid;
    logic                    hazard, fits01, rd_fire, wr_ready, enq0, enq1;
    logic [1:0]              mode, n_pop, n_enq;
    logic [NUM_RD-1:0][31:0] rsp_data;

    // NOTE: every always_comb assigns defaults first so no path leaves a variable unassigned (no latches).
    always_comb begin
        ent_valid = '0;
        for (int i = 0; i < WBUF_DEPTH; i++)
            ent_valid[i] = {1'b0, PTR_W'(i) - head_q} < count_q;
    end

`ifdef RF_WBUF_BYPASS_EN
    logic [NUM_RD-1:0]       byp_hit_d, byp_hit_q;
    logic [NUM_RD-1:0][31:0] byp_data_d, byp_data_q;

    assign hazard = 1'b0;

    // Walk oldest to youngest so the last match (youngest write) wins; same-cycle pops still count.
    always_comb begin
        byp_hit_d  = '0;
        byp_data_d = '0;
        for (int j = 0; j < NUM_RD; j++)
            for (int k = 0; k < WBUF_DEPTH; k++)
                if (bus.rd_mask[j] && (CNT_W'(k) < count_q) &&
                    (bus.rd_addr[j] == fifo_addr_q[head_q + PTR_W'(k)])) begin
                    byp_hit_d[j]  = 1'b1;
                    byp_data_d[j] = fifo_data_q[head_q + PTR_W'(k)];
                end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byp_hit_q  <= '0;
            byp_data_q <= '0;
        end else begin
            byp_hit_q  <= rd_fire ? byp_hit_d : '0;
            byp_data_q <= byp_data_d;
        end
    end
`else
    always_comb begin
        hazard = 1'b0;
        for (int j = 0; j < NUM_RD; j++)
            for (int i = 0; i < WBUF_DEPTH; i++)
                if (bus.rd_mask[j] && ent_valid[i] && (bus.rd_addr[j] == fifo_addr_q[i]))
                    hazard = 1'b1;
    end
`endif

    assign fits01   = ~|bus.rd_mask[NUM_RD-1:NUM_BRAMS];
    assign wr_ready = ~reset && (count_q <= CNT_W'(WBUF_DEPTH - 2));
    assign enq0     = bus.wr_valid[0] & wr_ready;
    assign enq1     = bus.wr_valid[1] & wr_ready;
    assign n_enq    = {1'b0, enq0} + {1'b0, enq1};

    // Priority: near-full drain, then reads, then opportunistic drain, then idle.
    always_comb begin
        mode    = MODE_IDLE;
        n_pop   = 2'd0;
        rd_fire = 1'b0;
        if (reset) begin
            mode = MODE_IDLE;
        end else if (count_q >= CNT_W'(WBUF_DEPTH - 2)) begin
            mode  = MODE_WR2;
            n_pop = 2'd2;
        end else if (bus.rd_valid && !hazard) begin
            rd_fire = 1'b1;
            if (fits01 && (count_q != '0)) begin
                mode  = MODE_WR1RD;
                n_pop = 2'd1;
            end else begin
                mode = MODE_RD2;
            end
        end else if (count_q >= CNT_W'(2)) begin
            mode  = MODE_WR2;
            n_pop = 2'd2;
        end else if (count_q == CNT_W'(1)) begin
            mode  = MODE_WR1RD;
            n_pop = 2'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_mask_q  <= '0;
        end else begin
            head_q      <= head_q + PTR_W'(n_pop);
            tail_q      <= tail_q + PTR_W'(n_enq);
            count_q     <= count_q + CNT_W'(n_enq) - CNT_W'(n_pop);
            rsp_valid_q <= rd_fire;
            rsp_mask_q  <= rd_fire ? bus.rd_mask : '0;
        end
    end

    // NOTE: FIFO storage has no reset; ent_valid and count_q hide stale entries, so only pointers reset.
    always_ff @(posedge clk) begin
        if (enq0) begin
            fifo_addr_q[tail_q] <= bus.wr_addr[0];
            fifo_data_q[tail_q] <= bus.wr_data[0];
        end
        if (enq1) begin
            fifo_addr_q[tail_q + PTR_W'(enq0)] <= bus.wr_addr[1];
            fifo_data_q[tail_q + PTR_W'(enq0)] <= bus.wr_data[1];
        end
    end

    always_comb begin
        rsp_data = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            rsp_data[j] = rsp_mask_q[j] ? bus.rf_read_data[j] : 32'd0;
`ifdef RF_WBUF_BYPASS_EN
            if (byp_hit_q[j])
                rsp_data[j] = byp_data_q[j];
`endif
        end
    end

    assign bus.wr_ready      = wr_ready;
    assign bus.rd_ready      = rd_fire;
    assign bus.rf_mode       = mode;
    assign bus.rf_write_addr = {fifo_addr_q[head_q + PTR_W'(1)], fifo_addr_q[head_q]};
    assign bus.rf_write_data = {fifo_data_q[head_q + PTR_W'(1)], fifo_data_q[head_q]};
    assign bus.rf_read_addr  = rd_fire ? bus.rd_addr : '0;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_mask      = rsp_mask_q;
    assign bus.rsp_data      = rsp_data;
endmodule
